// File: rtl/seg7_capture.sv
// Captures a multiplexed, active-low 7-segment display scan into a hex frame.
// Optional decimal-point capture is enabled by defining SEG7_DP_EN.
module seg7_capture #(
  parameter int unsigned NDIG       = 8,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [6:0]          seg_n,
  input  logic [NDIG-1:0]     dig_n,
`ifdef SEG7_DP_EN
  input  logic                dp_n,
  output logic [NDIG-1:0]     dp_mask,
`endif
  output logic [4*NDIG-1:0]   value,
  output logic                valid,
  output logic                err
);

  localparam int unsigned CW = 8;
`ifdef SEG7_DP_EN
  localparam int unsigned SW = NDIG + 8;
`else
  localparam int unsigned SW = NDIG + 7;
`endif

  typedef enum logic [1:0] {IDLE, TRACK, COMMIT} state_t;

  state_t              state, state_next;
  logic                commit_c;
  logic [CW-1:0]       cnt;
  logic [SW-1:0]       prev;
  logic [NDIG-1:0]     bitmap;
  logic [4*NDIG-1:0]   shadow;
  logic                ferr;
  logic [NDIG-1:0]     sel_c;
  logic                cand_c;
  logic                same_c;
  logic                capture_c;
  logic [SW-1:0]       sample_c;
  logic [4:0]          dec_c;
`ifdef SEG7_DP_EN
  logic [NDIG-1:0]     shadow_dp;
`endif

  // Returns {undecodable, nibble} for an active-high gfedcba pattern.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F: decode = 5'h00;
      7'h06: decode = 5'h01;
      7'h5B: decode = 5'h02;
      7'h4F: decode = 5'h03;
      7'h66: decode = 5'h04;
      7'h6D: decode = 5'h05;
      7'h7D: decode = 5'h06;
      7'h07: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h6F: decode = 5'h09;
      7'h77: decode = 5'h0A;
      7'h7C: decode = 5'h0B;
      7'h39: decode = 5'h0C;
      7'h5E: decode = 5'h0D;
      7'h79: decode = 5'h0E;
      7'h71: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  assign sel_c  = ~dig_n;
  assign cand_c = $onehot(sel_c);
`ifdef SEG7_DP_EN
  assign sample_c = {dp_n, seg_n, dig_n};
`else
  assign sample_c = {seg_n, dig_n};
`endif
  assign same_c    = (sample_c == prev) && (cnt != '0);
  // Count saturates at STABLE_CYC, so a held pattern is captured only once.
  assign capture_c = en && cand_c && same_c && (cnt == CW'(STABLE_CYC - 1));
  assign dec_c     = decode(~seg_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    commit_c   = 1'b0;
    case (state)
      IDLE:   if (en) state_next = TRACK;
      TRACK: begin
        if (!en) begin
          state_next = IDLE;
        end else if (&bitmap) begin
          commit_c   = 1'b1;
          state_next = COMMIT;
        end
      end
      COMMIT: state_next = en ? TRACK : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      prev   <= '0;
      bitmap <= '0;
      shadow <= '0;
      ferr   <= 1'b0;
      value  <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
`ifdef SEG7_DP_EN
      shadow_dp <= '0;
      dp_mask   <= '0;
`endif
    end else begin
      valid <= commit_c;
      if (commit_c) begin
        value <= shadow;
        err   <= ferr;
`ifdef SEG7_DP_EN
        dp_mask <= shadow_dp;
`endif
      end
      if (!en) begin
        cnt    <= '0;
        bitmap <= '0;
        ferr   <= 1'b0;
      end else begin
        if (!cand_c) begin
          cnt <= '0;
        end else if (same_c) begin
          if (cnt < CW'(STABLE_CYC)) cnt <= cnt + CW'(1);
        end else begin
          cnt  <= CW'(1);
          prev <= sample_c;
        end
        // A capture landing on the commit edge seeds the next frame.
        if (commit_c) begin
          bitmap <= capture_c ? sel_c : '0;
          ferr   <= capture_c & dec_c[4];
        end else if (capture_c) begin
          bitmap <= bitmap | sel_c;
          ferr   <= ferr | dec_c[4];
        end
        if (capture_c) begin
          for (int i = 0; i < int'(NDIG); i++) begin
            if (sel_c[i]) begin
              shadow[4*i +: 4] <= dec_c[3:0];
`ifdef SEG7_DP_EN
              shadow_dp[i] <= ~dp_n;
`endif
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed self-checking bench for seg7_capture (NDIG=8, STABLE_CYC=4).
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [6:0]  seg_n;
  logic [7:0]  dig_n;
  logic [31:0] value;
  logic        valid;
  logic        err;
`ifdef SEG7_DP_EN
  logic        dp_n;
  logic [7:0]  dp_mask;
`endif

  int nvec  = 0;
  int nerr  = 0;
  int vcnt  = 0;
  int dp_digit = -1;

  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_capture #(.NDIG(8), .STABLE_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .seg_n (seg_n),
    .dig_n (dig_n),
`ifdef SEG7_DP_EN
    .dp_n    (dp_n),
    .dp_mask (dp_mask),
`endif
    .value (value),
    .valid (valid),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid === 1'b1) vcnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic show(input logic [7:0] dn, input logic [6:0] seg_on, input int cyc);
    @(negedge clk);
    dig_n = dn;
    seg_n = ~seg_on;
`ifdef SEG7_DP_EN
    dp_n = !(dp_digit >= 0 && dn == ~(8'(1) << dp_digit));
`endif
    repeat (cyc - 1) @(negedge clk);
  endtask

  task automatic idle(input int cyc);
    show(8'hFF, 7'h00, cyc);
  endtask

  task automatic scan(input logic [31:0] f, input int bad_d, input logic [6:0] bad_seg,
                      input int short_d);
    for (int i = 0; i < 8; i++)
      show(~(8'(1) << i), (i == bad_d) ? bad_seg : SEG[f[4*i +: 4]], (i == short_d) ? 3 : 6);
    idle(4);
  endtask

  task automatic en_pulse_low();
    @(negedge clk); en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; seg_n = 7'h7F; dig_n = 8'hFF;
`ifdef SEG7_DP_EN
    dp_n = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("reset_value", value, 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Basic full scan
    scan(32'h1234ABCD, -1, 7'h00, -1);
    check("scan1_vcnt", 32'(vcnt), 32'd1);
    check("scan1_value", value, 32'h1234ABCD);
    check("scan1_err", 32'(err), 32'h0);

    // Digit 2 too short: no frame, then clean rescan
    scan(32'h76543210, -1, 7'h00, 2);
    check("short_no_valid", 32'(vcnt), 32'd1);
    check("short_value_held", value, 32'h1234ABCD);
    en_pulse_low();
    check("enlow_value_held", value, 32'h1234ABCD);
    scan(32'h76543210, -1, 7'h00, -1);
    check("rescan_vcnt", 32'(vcnt), 32'd2);
    check("rescan_value", value, 32'h76543210);

    // Undecodable digit 5 (segment a only)
    scan(32'hFE954321, 5, 7'h01, -1);
    check("bad_vcnt", 32'(vcnt), 32'd3);
    check("bad_value", value, 32'hFE054321);
    check("bad_err", 32'(err), 32'h1);

    // Clean frame clears err
    scan(32'h1234ABCD, -1, 7'h00, -1);
    check("clean_err", 32'(err), 32'h0);
    check("clean_vcnt", 32'(vcnt), 32'd4);

    // Blank digit 0
    scan(32'h87654321, 0, 7'h00, -1);
    check("blank_value", value, 32'h87654320);
    check("blank_err", 32'(err), 32'h1);

    // Multiple digits selected: ignored mid-frame
    for (int i = 0; i < 4; i++) show(~(8'(1) << i), SEG[4'(i == 0 ? 12 : i == 1 ? 3 : i == 2 ? 13 : 2)], 6);
    show(8'b11110011, SEG[5], 10);
    check("multi_no_valid", 32'(vcnt), 32'd5);
    for (int i = 4; i < 8; i++) show(~(8'(1) << i), SEG[4'(i == 4 ? 14 : i == 5 ? 1 : i == 6 ? 15 : 0)], 6);
    idle(4);
    check("multi_vcnt", 32'(vcnt), 32'd6);
    check("multi_value", value, 32'h0F1E2D3C);
    check("multi_err", 32'(err), 32'h0);

    // Reset after 5 captured digits discards the partial frame
    for (int i = 0; i < 5; i++) show(~(8'(1) << i), SEG[4'(i)], 6);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midrst_value", value, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 5; i < 8; i++) show(~(8'(1) << i), SEG[4'(i)], 6);
    idle(4);
    check("midrst_no_valid", 32'(vcnt), 32'd6);
    check("midrst_value_zero", value, 32'h0);
    en_pulse_low();
    scan(32'h1234ABCD, -1, 7'h00, -1);
    check("postrst_vcnt", 32'(vcnt), 32'd7);
    check("postrst_value", value, 32'h1234ABCD);

`ifdef SEG7_DP_EN
    dp_digit = 3;
    scan(32'h1234ABCD, -1, 7'h00, -1);
    dp_digit = -1;
    check("dp_vcnt", 32'(vcnt), 32'd8);
    check("dp_mask", 32'(dp_mask), 32'h08);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
